// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding plus small bit-level helpers
// used by both the RX and TX sides.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } e_rx_state;

   // Parity operands are zero-padded to this width; padding never changes the result.
   localparam int PAR_MAX_W = 32;

   function automatic logic calc_parity(input logic [PAR_MAX_W-1:0] data,
                                        input logic                 par_type);
      return par_type ? ~^data : ^data;
   endfunction

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit timing for the UART receiver: edge/bit counters and the 3-sample
// majority voter centred on the middle of each bit.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int PRESC_W   = 6,
   parameter int BIT_CNT_W = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 rx_i,
   input  logic [PRESC_W-1:0]   prescale_i,
   input  logic                 clr_i,
   output logic [BIT_CNT_W-1:0] bit_cnt_o,
   output logic                 vote_o,
   output logic                 sample_last_o,
   output logic                 sampled_bit_o,
   output logic                 sample_done_o,
   output logic                 bit_end_o
);

   localparam logic [PRESC_W-1:0]   ONE_E = PRESC_W'(1);
   localparam logic [BIT_CNT_W-1:0] ONE_B = BIT_CNT_W'(1);

   logic [PRESC_W-1:0]   edge_cnt_q, edge_cnt_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic                 samp_a_q, samp_b_q;
   logic                 sampled_bit_q, sample_done_q;

   logic [PRESC_W-1:0] half, pt_a, pt_c, last_pt;

   always_comb begin
      half    = prescale_i >> 1;
      pt_a    = half - ONE_E;
      pt_c    = half + ONE_E;
      last_pt = prescale_i - ONE_E;
   end

   assign bit_end_o     = (edge_cnt_q == last_pt);
   assign sample_last_o = (edge_cnt_q == pt_c);
   assign vote_o        = maj3(samp_a_q, samp_b_q, rx_i);
   assign bit_cnt_o     = bit_cnt_q;
   assign sampled_bit_o = sampled_bit_q;
   assign sample_done_o = sample_done_q;

   // Counters sit at zero whenever the FSM is (or is about to be) idle, so the
   // cycle that detects the start edge is always edge_cnt 0 of the start bit.
   always_comb begin
      edge_cnt_d = edge_cnt_q + ONE_E;
      bit_cnt_d  = bit_cnt_q;
      if (clr_i) begin
         edge_cnt_d = '0;
         bit_cnt_d  = '0;
      end else if (bit_end_o) begin
         edge_cnt_d = '0;
         bit_cnt_d  = bit_cnt_q + ONE_B;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         edge_cnt_q    <= '0;
         bit_cnt_q     <= '0;
         samp_a_q      <= 1'b1;
         samp_b_q      <= 1'b1;
         sampled_bit_q <= 1'b1;
         sample_done_q <= 1'b0;
      end else begin
         edge_cnt_q    <= edge_cnt_d;
         bit_cnt_q     <= bit_cnt_d;
         samp_a_q      <= (edge_cnt_q == pt_a) ? rx_i : samp_a_q;
         samp_b_q      <= (edge_cnt_q == half) ? rx_i : samp_b_q;
         sampled_bit_q <= sample_last_o ? vote_o : sampled_bit_q;
         sample_done_q <= sample_last_o;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detection, LSB-first data capture, optional parity and
// stop check, with one-cycle result pulses.
//
//   state  | meaning
//   IDLE   | line idle; RX_IN low latches config and starts a frame
//   START  | confirm start bit at its end; a high vote is a glitch
//   DATA   | shift WIDTH voted bits, LSB first
//   PARITY | compare voted parity bit against the captured byte
//   STOP   | judge stop bit at its last sample point, then IDLE
module uart_rx
   import uart_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int PRESC_W = 6
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               RX_IN,
   input  logic               PAR_EN,
   input  logic               PAR_TYPE,
   input  logic [PRESC_W-1:0] PRESCALE,
   output logic [WIDTH-1:0]   P_DATA,
   output logic               DATA_VALID,
   output logic               PAR_ERR,
   output logic               STP_ERR
);

   localparam int BIT_CNT_W = $clog2(WIDTH + 3);
   localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(WIDTH);

   e_rx_state            state_q, state_d;
   logic                 par_en_q, par_en_d;
   logic                 par_type_q, par_type_d;
   logic [PRESC_W-1:0]   prescale_q, prescale_d;
   logic [WIDTH-1:0]     shift_q, shift_d;
   logic                 par_mis_q, par_mis_d;
   logic [WIDTH-1:0]     p_data_q, p_data_d;
   logic                 data_valid_q, data_valid_d;
   logic                 par_err_q, par_err_d;
   logic                 stp_err_q, stp_err_d;

   logic [PRESC_W-1:0]   prescale_eff;
   logic                 clr;
   logic [BIT_CNT_W-1:0] bit_cnt;
   logic                 vote, sample_last, sampled_bit, sample_done, bit_end;

   // The live PRESCALE times the detect cycle; the latched copy times the rest.
   assign prescale_eff = (state_q == IDLE) ? PRESCALE : prescale_q;
   assign clr          = (state_d == IDLE);

   uart_rx_sampler #(
      .PRESC_W   (PRESC_W),
      .BIT_CNT_W (BIT_CNT_W)
   ) u_sampler (
      .clk_i         (CLK),
      .rst_ni        (RST),
      .rx_i          (RX_IN),
      .prescale_i    (prescale_eff),
      .clr_i         (clr),
      .bit_cnt_o     (bit_cnt),
      .vote_o        (vote),
      .sample_last_o (sample_last),
      .sampled_bit_o (sampled_bit),
      .sample_done_o (sample_done),
      .bit_end_o     (bit_end)
   );

   always_comb begin
      state_d      = state_q;
      par_en_d     = par_en_q;
      par_type_d   = par_type_q;
      prescale_d   = prescale_q;
      shift_d      = shift_q;
      par_mis_d    = par_mis_q;
      p_data_d     = p_data_q;
      data_valid_d = 1'b0;
      par_err_d    = 1'b0;
      stp_err_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (!RX_IN) begin
               state_d    = START;
               par_en_d   = PAR_EN;
               par_type_d = PAR_TYPE;
               prescale_d = PRESCALE;
               par_mis_d  = 1'b0;
            end
         end
         START: begin
            if (bit_end) state_d = sampled_bit ? IDLE : DATA;
         end
         DATA: begin
            if (sample_done) shift_d = {sampled_bit, shift_q[WIDTH-1:1]};
            if (bit_end && (bit_cnt == LAST_DATA_BIT)) state_d = par_en_q ? PARITY : STOP;
         end
         PARITY: begin
            if (sample_done) par_mis_d = (sampled_bit != calc_parity(PAR_MAX_W'(shift_q), par_type_q));
            if (bit_end) state_d = STOP;
         end
         STOP: begin
            // Judged on the live vote so results appear the cycle after the last
            // sample and IDLE is reached well before a back-to-back start edge.
            if (sample_last) begin
               state_d      = IDLE;
               data_valid_d = vote & ~par_mis_q;
               par_err_d    = par_mis_q;
               stp_err_d    = ~vote;
               if (vote && !par_mis_q) p_data_d = shift_q;
            end else if (bit_end) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q      <= IDLE;
         par_en_q     <= 1'b0;
         par_type_q   <= 1'b0;
         prescale_q   <= '0;
         shift_q      <= '0;
         par_mis_q    <= 1'b0;
         p_data_q     <= '0;
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         par_en_q     <= par_en_d;
         par_type_q   <= par_type_d;
         prescale_q   <= prescale_d;
         shift_q      <= shift_d;
         par_mis_q    <= par_mis_d;
         p_data_q     <= p_data_d;
         data_valid_q <= data_valid_d;
         par_err_q    <= par_err_d;
         stp_err_q    <= stp_err_d;
      end
   end

   assign P_DATA     = p_data_q;
   assign DATA_VALID = data_valid_q;
   assign PAR_ERR    = par_err_q;
   assign STP_ERR    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serialises frames onto RX_IN and scores every output pulse
// (cycle, flags, P_DATA) against expectations from a table and a frame-level model.
module tb_uart_rx;

   logic       CLK = 1'b0;
   logic       RST;
   logic       RX_IN;
   logic       PAR_EN;
   logic       PAR_TYPE;
   logic [5:0] PRESCALE;
   logic [7:0] P_DATA;
   logic       DATA_VALID;
   logic       PAR_ERR;
   logic       STP_ERR;

   always #5 CLK = ~CLK;

   uart_rx #(.WIDTH(8), .PRESC_W(6)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .RX_IN      (RX_IN),
      .PAR_EN     (PAR_EN),
      .PAR_TYPE   (PAR_TYPE),
      .PRESCALE   (PRESCALE),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID),
      .PAR_ERR    (PAR_ERR),
      .STP_ERR    (STP_ERR)
   );

   typedef struct {
      int         cyc;
      logic [2:0] flags;   // {DATA_VALID, PAR_ERR, STP_ERR}
      logic [7:0] pdata;
   } ev_t;

   typedef struct {
      int         p;
      bit         pen;
      bit         ptype;
      logic [7:0] data;
      bit         par_bit;
      bit         stop_bit;
      logic [2:0] flags;
      logic [7:0] pdata;
      int         lat;
   } vec_t;

   ev_t        exp_q[$];
   ev_t        act_q[$];
   vec_t       vecs[9];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] model_pdata;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      ev_t e;
      if (DATA_VALID || PAR_ERR || STP_ERR) begin
         e.cyc   = cyc;
         e.flags = {DATA_VALID, PAR_ERR, STP_ERR};
         e.pdata = P_DATA;
         act_q.push_back(e);
      end
   end

   initial begin
      #990000;
      $display("FAIL watchdog: cycle budget exhausted at cycle %0d, required completion", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      RX_IN    = 1'b1;
      PRESCALE = 6'd8;
      PAR_EN   = 1'b0;
      PAR_TYPE = 1'b0;
      repeat (n) @(negedge CLK);
   endtask

   // Config is valid on the detect cycle and during the stop bit; in between it
   // is scrambled to show the receiver ignores mid-frame changes.
   task automatic drive_frame(input int p, input bit pen, input bit ptype,
                              input logic [7:0] data, input bit par_bit,
                              input bit stop_bit, input bit glitch,
                              input logic [2:0] flags, input logic [7:0] pdata,
                              input int lat);
      bit  bits[$];
      ev_t e;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(data[i]);
      if (pen) bits.push_back(par_bit);
      bits.push_back(stop_bit);
      for (int i = 0; i < bits.size(); i++) begin
         for (int c = 0; c < p; c++) begin
            RX_IN = bits[i] ^ (glitch && i >= 1 && i <= 8 && c == p / 2);
            if (i == 0 || i == bits.size() - 1) begin
               PRESCALE = 6'(p);
               PAR_EN   = pen;
               PAR_TYPE = ptype;
               if (i == 0 && c == 0 && flags != 3'b000) begin
                  e.cyc   = cyc + lat;
                  e.flags = flags;
                  e.pdata = pdata;
                  exp_q.push_back(e);
               end
            end else begin
               PRESCALE = 6'($urandom_range(0, 63));
               PAR_EN   = 1'($urandom);
               PAR_TYPE = 1'($urandom);
            end
            @(negedge CLK);
         end
      end
   endtask

   task automatic check_events(input string tag);
      ev_t e;
      ev_t a;
      idle(40);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (act_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s.missing: got no pulse, expected flags %b at cycle %0d", tag, e.flags, e.cyc);
         end else begin
            a = act_q.pop_front();
            chk({tag, ".cycle"}, a.cyc, e.cyc);
            chk({tag, ".flags"}, int'(a.flags), int'(e.flags));
            chk({tag, ".pdata"}, int'(a.pdata), int'(e.pdata));
         end
      end
      chk({tag, ".extra_pulses"}, act_q.size(), 0);
      act_q.delete();
      chk({tag, ".p_data_hold"}, int'(P_DATA), int'(model_pdata));
   endtask

   initial begin
      int         p;
      bit         pen, ptype, flip, stop, ep, pe, se, dv;
      logic [7:0] data, pd;
      logic [2:0] fl;
      int         lat, gap;

      RST = 1'b0;
      RX_IN = 1'b1;
      PAR_EN = 1'b0;
      PAR_TYPE = 1'b0;
      PRESCALE = 6'd8;
      model_pdata = 8'h00;

      //          P   pen   ptype data   parb  stop  {dv,pe,se} pdata  lat
      vecs[0] = '{8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 3'b100, 8'hA5, 78};
      vecs[1] = '{8,  1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 3'b100, 8'hA5, 86};
      vecs[2] = '{16, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 3'b100, 8'h3C, 170};
      vecs[3] = '{16, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 3'b010, 8'h3C, 170};
      vecs[4] = '{8,  1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 3'b001, 8'h3C, 78};
      vecs[5] = '{8,  1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 3'b011, 8'h3C, 86};
      vecs[6] = '{32, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'b100, 8'h00, 306};
      vecs[7] = '{10, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 3'b100, 8'hFF, 107};
      vecs[8] = '{12, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 3'b100, 8'h81, 116};

      repeat (3) @(negedge CLK);
      chk("reset.p_data", int'(P_DATA), 0);
      chk("reset.data_valid", int'(DATA_VALID), 0);
      chk("reset.par_err", int'(PAR_ERR), 0);
      chk("reset.stp_err", int'(STP_ERR), 0);
      RST = 1'b1;
      idle(5);

      for (int i = 0; i < 9; i++) begin
         drive_frame(vecs[i].p, vecs[i].pen, vecs[i].ptype, vecs[i].data, vecs[i].par_bit,
                     vecs[i].stop_bit, 1'b0, vecs[i].flags, vecs[i].pdata, vecs[i].lat);
         model_pdata = vecs[i].pdata;
         check_events($sformatf("vec%0d", i));
      end

      // Three-cycle low pulse is a false start, then a clean frame.
      RX_IN = 1'b0;
      repeat (3) @(negedge CLK);
      check_events("short_start");
      drive_frame(8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0, 3'b100, 8'h81, 78);
      model_pdata = 8'h81;
      check_events("after_short");

      // One-cycle glitch at the centre sample of every data bit.
      drive_frame(8, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b1, 1'b1, 3'b100, 8'hF0, 78);
      model_pdata = 8'hF0;
      check_events("glitch");

      // Back-to-back frames at P=32: pulses exactly 320 cycles apart.
      drive_frame(32, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 3'b100, 8'h11, 306);
      drive_frame(32, 1'b0, 1'b0, 8'hEE, 1'b0, 1'b1, 1'b0, 3'b100, 8'hEE, 306);
      model_pdata = 8'hEE;
      check_events("back_to_back");

      // Break: line held low, stop error every 78 cycles; third start cut short.
      PRESCALE = 6'd8;
      PAR_EN   = 1'b0;
      RX_IN    = 1'b0;
      exp_q.push_back('{cyc + 78,  3'b001, model_pdata});
      exp_q.push_back('{cyc + 156, 3'b001, model_pdata});
      repeat (160) @(negedge CLK);
      check_events("break");

      // Reset mid-frame: no pulse afterwards, P_DATA cleared.
      PRESCALE = 6'd8;
      PAR_EN   = 1'b0;
      RX_IN    = 1'b0;
      repeat (12) @(negedge CLK);
      RX_IN = 1'b1;
      repeat (20) @(negedge CLK);
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      model_pdata = 8'h00;
      check_events("mid_reset");

      // Random frames against the frame-level model.
      for (int n = 0; n < 200; n++) begin
         p     = 2 * int'($urandom_range(4, 14));
         pen   = 1'($urandom);
         ptype = 1'($urandom);
         data  = 8'($urandom);
         flip  = ($urandom_range(0, 7) == 0);
         stop  = ($urandom_range(0, 7) != 0);
         ep    = ptype ? ~^data : ^data;
         pe    = pen && flip;
         se    = !stop;
         dv    = !pe && !se;
         fl    = {dv, pe, se};
         pd    = dv ? data : model_pdata;
         lat   = (pen ? 10 : 9) * p + p / 2 + 2;
         drive_frame(p, pen, ptype, data, ep ^ flip, stop, 1'b0, fl, pd, lat);
         model_pdata = pd;
         gap = stop ? int'($urandom_range(0, 3)) : p + 4;
         if (gap > 0) idle(gap);
      end
      check_events("random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
